// File: rtl/verifier_io_tau_seq.sv
// verifier_io_tau_seq: per-round tau challenge sequencer for the io-element; define VERIFIER_TAU_RANGE_CHECK_EN to flag tau_in >= F_Q.
module verifier_io_tau_seq #(
    parameter int nCopyBits = 2,
    parameter int nRounds = nCopyBits,
    parameter int F_NBITS = 61,
    parameter logic [F_NBITS-1:0] F_Q = 61'h1FFF_FFFF_FFFF_FFFF
) (
    input  logic                           clk,
    input  logic                           rstb,
    input  logic                           start,
    input  logic [F_NBITS-1:0]             tau_in,
    input  logic                           tau_valid,
    output logic                           tau_ready,
    input  logic                           elem_ready,
    input  logic                           elem_ready_pulse,
    output logic                           elem_en,
    output logic                           elem_restart,
    output logic [F_NBITS-1:0]             tau,
    output logic [F_NBITS-1:0]             m_tau_p1,
    output logic [$clog2(nRounds+1)-1:0]   round,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);
    localparam int RW = $clog2(nRounds + 1);
    localparam logic [RW-1:0] LAST = RW'(nRounds);
    typedef enum logic [2:0] {ST_IDLE, ST_WTAU, ST_ISSUE, ST_RUN, ST_DONE} state_t;
    state_t state, state_nxt;
    logic start_dly, bad_tau;
    logic [RW-1:0] round_inc;
    logic [F_NBITS-1:0] m_nxt;
    assign round_inc = round + 1'b1;
    assign busy = state != ST_IDLE;
    // canonical (1 - tau) mod F_Q: tau==1 maps to 0 rather than F_Q
    assign m_nxt = tau_in == '0 ? F_NBITS'(1) :
                   tau_in == F_NBITS'(1) ? '0 : F_Q + F_NBITS'(1) - tau_in;
`ifdef VERIFIER_TAU_RANGE_CHECK_EN
    assign bad_tau = tau_in >= F_Q;
    always_ff @(posedge clk)
        err <= rstb ? 1'b0 : err | (tau_ready & bad_tau);
`else
    assign bad_tau = 1'b0;
    assign err = 1'b0;
`endif
    always_comb begin
        state_nxt = state;
        tau_ready = 1'b0;
        elem_en = 1'b0;
        elem_restart = 1'b0;
        case (state)
            ST_IDLE:  state_nxt = (start & ~start_dly) ? ST_WTAU : ST_IDLE;
            ST_WTAU: if (tau_valid) begin
                tau_ready = 1'b1;
                state_nxt = bad_tau ? ST_IDLE : ST_ISSUE;
            end
            ST_ISSUE: if (elem_ready) begin
                elem_en = 1'b1;
                elem_restart = round == '0;
                state_nxt = ST_RUN;
            end
            ST_RUN: if (elem_ready_pulse) state_nxt = round_inc == LAST ? ST_DONE : ST_WTAU;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (rstb) begin
            tau_ready = 1'b0;
            elem_en = 1'b0;
            elem_restart = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rstb) begin
            state <= ST_IDLE;
            start_dly <= 1'b1;
            tau <= '0;
            m_tau_p1 <= '0;
            round <= '0;
            done <= 1'b0;
        end else begin
            state <= state_nxt;
            start_dly <= start;
            done <= state == ST_DONE;
            if (state == ST_IDLE && state_nxt == ST_WTAU) round <= '0;
            if (state == ST_RUN && elem_ready_pulse) round <= round_inc;
            if (tau_ready && !bad_tau) begin
                tau <= tau_in;
                m_tau_p1 <= m_nxt;
            end
        end
    end
endmodule

// File: tb/tb_verifier_io_tau_seq.sv
// tb_verifier_io_tau_seq: table-driven sequences with an io-element model and expected-round scoreboard.
module tb_verifier_io_tau_seq;
    localparam logic [60:0] Q = 61'h1FFF_FFFF_FFFF_FFFF;
    logic clk = 1'b0, rstb = 1'b1, start = 1'b0, tau_valid = 1'b0, elem_ready = 1'b1, elem_ready_pulse = 1'b0;
    logic [60:0] tau_in = '0;
    logic tau_ready, elem_en, elem_restart, busy, done, err;
    logic [60:0] tau, m_tau_p1;
    logic [1:0] round;
    int pass = 0, total = 0, en_cnt = 0, cyc = 0, last_pulse_cyc = 0;
    typedef struct { logic [60:0] t; logic [60:0] m; } vec_t;
    typedef struct { logic [60:0] t; logic [60:0] m; logic rs; logic [1:0] rd; } sb_t;
    vec_t vecs[6];
    sb_t sb[$];

    verifier_io_tau_seq dut (
        .clk(clk), .rstb(rstb), .start(start), .tau_in(tau_in), .tau_valid(tau_valid),
        .tau_ready(tau_ready), .elem_ready(elem_ready), .elem_ready_pulse(elem_ready_pulse),
        .elem_en(elem_en), .elem_restart(elem_restart), .tau(tau), .m_tau_p1(m_tau_p1),
        .round(round), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // io-element model: pops the expected round on each enable, answers 10 cycles later
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (elem_en) begin
                en_cnt++;
                chk("sb_nonempty", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("en_tau", tau, e.t);
                    chk("en_m_tau_p1", m_tau_p1, e.m);
                    chk("en_restart", elem_restart, e.rs);
                    chk("en_round", round, e.rd);
                end
                @(negedge clk);
                chk("en_width", elem_en, 0);
                repeat (8) @(negedge clk);
                #1 elem_ready_pulse = 1'b1;
                last_pulse_cyc = cyc;
                @(negedge clk);
                #1 elem_ready_pulse = 1'b0;
            end
        end
    end

    task automatic feed_tau(input logic [60:0] t, input logic [60:0] m, input int r, input bit stall);
        bit got = 0;
        tau_in = t;
        tau_valid = 1'b1;
        if (stall) elem_ready = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            #1;
            if (tau_ready) got = 1;
            else tick();
        end
        chk("tau_ready_seen", got, 1);
        if (got) sb.push_back('{t: t, m: m, rs: r == 0, rd: 2'(r)});
        tick();
        tau_valid = 1'b0;
        #1;
        chk("tau_ready_one_cycle", tau_ready, 0);
    endtask

    task automatic wait_round(input int n);
        bit got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (round == 2'(n)) got = 1;
        end
        chk("round_advance", got, 1);
    endtask

    task automatic run_seq(input vec_t a, input vec_t b, input bit stall);
        int base = en_cnt;
        bit got = 0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_tau(a.t, a.m, 0, stall);
        if (stall) begin
            for (int k = 0; k < 20; k++) begin
                start = k[0];
                tick();
            end
            start = 1'b0;
            chk("stall_no_en", en_cnt, base);
            chk("stall_busy", busy, 1);
            elem_ready = 1'b1;
        end
        wait_round(1);
        feed_tau(b.t, b.m, 1, 1'b0);
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk("done_seen", got, 1);
        chk("done_latency", cyc - last_pulse_cyc, 2);
        chk("final_round", round, 2);
        chk("en_count", en_cnt - base, 2);
        chk("idle_at_done", busy, 0);
        chk("sb_drained", sb.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int base;
        bit saw;
        vecs[0] = '{t: 61'd5, m: Q - 61'd4};
        vecs[1] = '{t: 61'd0, m: 61'd1};
        vecs[2] = '{t: 61'd1, m: 61'd0};
        vecs[3] = '{t: 61'd2, m: Q - 61'd1};
        vecs[4] = '{t: Q - 61'd1, m: 61'd2};
        vecs[5] = '{t: 61'd12345, m: Q - 61'd12344};
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_en", elem_en, 0);
        chk("rst_tau", tau, 0);
        chk("rst_m", m_tau_p1, 0);
        chk("rst_round", round, 0);
        chk("rst_err", err, 0);
        start = 1'b1;
        tick();
        rstb = 1'b0;
        repeat (5) tick();
        chk("start_held_release", busy, 0);
        start = 1'b0;
        for (int i = 0; i < 6; i += 2) run_seq(vecs[i], vecs[i+1], i == 2);
        repeat (15) tick();
        chk("no_extra_seq", busy, 0);
        // reset during round 1 of a run
        base = en_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        feed_tau(vecs[0].t, vecs[0].m, 0, 1'b0);
        wait_round(1);
        feed_tau(vecs[3].t, vecs[3].m, 1, 1'b0);
        saw = 0;
        for (int k = 0; k < 50 && !saw; k++) begin
            @(negedge clk);
            if (en_cnt == base + 2) saw = 1;
        end
        chk("mid_en_seen", saw, 1);
        #1 rstb = 1'b1;
        start = 1'b1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tau", tau, 0);
        chk("mid_rst_m", m_tau_p1, 0);
        chk("mid_rst_round", round, 0);
        rstb = 1'b0;
        saw = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) saw = 1;
        end
        chk("mid_rst_quiet", saw, 0);
        chk("mid_rst_no_en", en_cnt, base + 2);
        start = 1'b0;
        chk("err_clear", err, 0);
`ifdef VERIFIER_TAU_RANGE_CHECK_EN
        base = en_cnt;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tau_in = Q;
        tau_valid = 1'b1;
        #1;
        chk("range_tau_ready", tau_ready, 1);
        tick();
        tau_valid = 1'b0;
        chk("range_err", err, 1);
        chk("range_idle", busy, 0);
        repeat (15) tick();
        chk("range_no_en", en_cnt, base);
        chk("range_err_sticky", err, 1);
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
